config_packer: RTL and testbench
================================

Name: config_packer

Overview:
- Host-side encoder for the configuration byte stream; it writes into the config FIFO that the config_passer drains.
- It accepts one request at a time: op, register address, byte count.
- For each request it emits one header byte followed by exactly Count payload bytes into the FIFO write port.
- Payload bytes are taken from a valid/ready data input for write ops, or are generated as padding for non-write ops, so the downstream byte counter always stays aligned.

Parameters:
- PAD_BYTE, 8'h00, payload value emitted for non-write ops (bit7=0).

Ports:
- CLK  input  1  clock, all logic on rising edge
- RSTn  input  1  reset, synchronous, active-low
- Req  input  1  request strobe, sampled only when ReqReady=1
- ReqWr  input  1  op: 1=write (header bit7=1), 0=non-write/skip
- ReqAddr  input  3  target register address, header bits5:3
- ReqCnt  input  3  payload byte count 0..7, header bits2:0
- ReqReady  output  1  high in IDLE only
- Din  input  8  payload byte for write ops
- DinValid  input  1  Din valid
- DinReady  output  1  Din consumed this cycle when DinValid & DinReady
- Full  input  1  FIFO full flag
- WINC  output  1  FIFO write strobe; must never be high while Full=1
- WData  output  8  FIFO write data
- Busy  output  1  state != IDLE
- PktCnt  output  8  completed-packet counter, wraps 255->0

Behaviour:
- Reset: when RSTn=0 at a clock edge, the block goes to state IDLE and clears the latched op/addr/count and Remaining to 0. PktCnt is cleared to 0.
- Reset mid-packet aborts the packet immediately; the FIFO then holds a partial packet, and flushing it is a system responsibility. Outputs during reset follow the IDLE decode: ReqReady=1, Busy=0, WINC=0, DinReady=0.
- Header byte format: {ReqWr, 1'b0, ReqAddr, ReqCnt}. Bit6 is always 0.
- WINC, WData, DinReady and ReqReady are combinational from state, Full and DinValid.
- Only one FIFO write can happen per cycle. An "accepted beat" is any cycle with WINC=1.
- IDLE:
  - ReqReady=1, WINC=0, DinReady=0.
  - When Req=1, latch Wr/Addr/Cnt and move to HEADER on the next cycle.
- HEADER:
  - WINC = ~Full, WData = header.
  - When Full=1, stay in HEADER with WINC=0; header data is held.
  - On a beat with Cnt=0: go to IDLE and increment PktCnt.
  - On a beat with Cnt>0: load Remaining=Cnt and go to PAYLOAD.
- PAYLOAD with Wr=1:
  - DinReady = ~Full, WINC = DinValid & ~Full, WData = Din.
  - Din is never consumed while Full=1.
- PAYLOAD with Wr=0:
  - DinReady=0, WINC = ~Full, WData = PAD_BYTE.
  - Din is not touched.
- Each PAYLOAD beat decrements Remaining.
  - A beat with Remaining=1 goes to IDLE and increments PktCnt in the same edge.
- Latency:
  - Req cycle to header on WData is 1 cycle when Full=0.
  - Back-to-back packets take Cnt+2 cycles each, because one IDLE cycle separates them.
- Req while Busy is ignored; there is no queueing.
- Full may toggle on any cycle. The only effect is that beats are stalled; byte order and byte count are unchanged.

Test Plan:
- Write, Full=0, Req with Wr=1, Addr=5, Cnt=3, then Din A1,A2,A3 continuously valid -> WData sequence AB,A1,A2,A3 on 4 consecutive WINC cycles; ReqReady again on the next cycle; PktCnt=1.
- Full held high for 2 cycles in HEADER of the above -> WINC=0 for those 2 cycles and WData held at AB; then the same 4-byte sequence with no loss or duplication.
- Skip op, Wr=0, Addr=2, Cnt=2 -> WData 12,00,00; DinReady stays 0 throughout and a pending DinValid byte remains unconsumed.
- Zero-count write, Wr=1, Addr=7, Cnt=0 -> single byte B8, return to IDLE; PktCnt increments.
- DinValid gaps: 2-byte write (Addr=1 -> header 8A) with DinValid low for 3 cycles between bytes -> exactly 3 WINC pulses; Busy stays high through the gap.
- Reset mid-payload: RSTn=0 for 1 cycle after the first payload byte of a Cnt=4 write -> next cycle IDLE, ReqReady=1, WINC=0, PktCnt=0; a new request then emits a correct packet. Also: Req asserted while Busy -> ignored, no extra header.

Source files
------------

// File: rtl/config_packer.sv
// config_packer: host-side encoder for the configuration byte stream.
// Each request becomes one header byte {wr, 0, addr, cnt} followed by exactly
// cnt payload bytes written into the config FIFO. Write ops pull their payload
// from the Din valid/ready port. Non-write ops emit PAD_BYTE so the downstream
// byte counter stays aligned.
module config_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Req,
  input  logic       ReqWr,
  input  logic [2:0] ReqAddr,
  input  logic [2:0] ReqCnt,
  output logic       ReqReady,
  input  logic [7:0] Din,
  input  logic       DinValid,
  output logic       DinReady,
  input  logic       Full,
  output logic       WINC,
  output logic [7:0] WData,
  output logic       Busy,
  output logic [7:0] PktCnt
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_remaining;
  logic [DATA_W-1:0]   r_pkt_cnt;

  state_t              w_state;
  logic [DATA_W-1:0]   w_header;
  logic                w_req_ready;
  logic                w_din_ready;
  logic                w_winc;
  logic [DATA_W-1:0]   w_wdata;

  assign w_header = {r_wr, 1'b0, r_addr, r_cnt};

  // Output decode; while RSTn is low the outputs already look like IDLE
  always_comb begin
    w_state     = RSTn ? r_state : S_IDLE;
    w_req_ready = 1'b0;
    w_din_ready = 1'b0;
    w_winc      = 1'b0;
    w_wdata     = w_header;
    case (w_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
      end
      S_HEADER: begin
        w_winc  = ~Full;
        w_wdata = w_header;
      end
      S_PAYLOAD: begin
        if (r_wr) begin
          w_din_ready = ~Full;
          w_winc      = DinValid & ~Full;
          w_wdata     = Din;
        end else begin
          w_winc      = ~Full;
          w_wdata     = PAD_BYTE;
        end
      end
      default: begin
        w_req_ready = 1'b0;
      end
    endcase
  end

  // Packet sequencer: latch request, emit header, count payload beats
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state     <= S_IDLE;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_remaining <= '0;
      r_pkt_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Req) begin
            r_wr    <= ReqWr;
            r_addr  <= ReqAddr;
            r_cnt   <= ReqCnt;
            r_state <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (w_winc) begin
            if (r_cnt == CNT_W'(0)) begin
              r_state   <= S_IDLE;
              r_pkt_cnt <= r_pkt_cnt + DATA_W'(1);
            end else begin
              r_remaining <= r_cnt;
              r_state     <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (w_winc) begin
            if (r_remaining == CNT_W'(1)) begin
              r_remaining <= '0;
              r_state     <= S_IDLE;
              r_pkt_cnt   <= r_pkt_cnt + DATA_W'(1);
            end else begin
              r_remaining <= r_remaining - CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ReqReady = w_req_ready;
  assign DinReady = w_din_ready;
  assign WINC     = w_winc;
  assign WData    = w_wdata;
  assign Busy     = (w_state != S_IDLE);
  assign PktCnt   = r_pkt_cnt;

endmodule

// File: tb/tb_config_packer.sv
// Bench for config_packer: an expected-byte queue model checked every cycle,
// plus hand-computed packet byte sequences for the directed scenarios.
module tb_config_packer;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       Req;
  logic       ReqWr;
  logic [2:0] ReqAddr;
  logic [2:0] ReqCnt;
  logic       ReqReady;
  logic [7:0] Din;
  logic       DinValid;
  logic       DinReady;
  logic       Full;
  logic       WINC;
  logic [7:0] WData;
  logic       Busy;
  logic [7:0] PktCnt;

  localparam logic [7:0] PAD = 8'h00;

  config_packer #(.PAD_BYTE(PAD)) dut (
    .CLK(CLK), .RSTn(RSTn), .Req(Req), .ReqWr(ReqWr), .ReqAddr(ReqAddr),
    .ReqCnt(ReqCnt), .ReqReady(ReqReady), .Din(Din), .DinValid(DinValid),
    .DinReady(DinReady), .Full(Full), .WINC(WINC), .WData(WData),
    .Busy(Busy), .PktCnt(PktCnt)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [7:0] data; int gap; } src_t;
  typedef enum int { K_HDR, K_WR, K_PAD } kind_t;
  typedef struct { logic [7:0] data; kind_t kind; bit last; } exp_t;

  src_t       src[$];   // host payload source: byte plus idle cycles before it
  exp_t       q[$];     // bytes the FIFO must still receive, in order
  logic [7:0] cap[$];   // bytes actually written, for the literal checks
  int         wcyc[$];
  int n_chk = 0, n_pass = 0, cyc = 0, exp_pkt = 0, dr_seen = 0, stall = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model and per-cycle compare, on the falling edge
  always @(negedge CLK) begin : model
    logic e_rr, e_busy, e_winc, e_dr;
    exp_t h;
    exp_t e;
    src_t s;
    cyc++;
    e_rr = 1'b1; e_busy = 1'b0; e_winc = 1'b0; e_dr = 1'b0;
    if (RSTn === 1'b1 && q.size() > 0) begin
      e_rr = 1'b0;
      e_busy = 1'b1;
      if (q[0].kind == K_WR) begin
        e_dr   = !Full;
        e_winc = DinValid && !Full;
        if (e_winc) chk("wdata_payload", WData, q[0].data);
      end else begin
        e_winc = !Full;
        chk("wdata_fixed", WData, q[0].data);
      end
    end
    chk("winc", 8'(WINC), 8'(e_winc));
    chk("req_ready", 8'(ReqReady), 8'(e_rr));
    chk("din_ready", 8'(DinReady), 8'(e_dr));
    chk("busy", 8'(Busy), 8'(e_busy));
    chk("pkt_cnt", PktCnt, 8'(exp_pkt));
    if (WINC === 1'b1) begin cap.push_back(WData); wcyc.push_back(cyc); end
    if (DinReady === 1'b1) dr_seen++;
    if (Busy === 1'b1 && WINC !== 1'b1) stall++;
    if (RSTn !== 1'b1) begin
      q.delete(); src.delete(); exp_pkt = 0;
    end else begin
      if (e_winc) begin
        e = q.pop_front();
        if (e.last) exp_pkt = (exp_pkt + 1) % 256;
      end
      if (e_dr && DinValid && src.size() > 0) s = src.pop_front();
      if (Req && e_rr) begin
        h.data = 8'(int'(ReqWr) * 128 + int'(ReqAddr) * 8 + int'(ReqCnt));
        h.kind = K_HDR;
        h.last = (ReqCnt == 3'd0);
        q.push_back(h);
        for (int i = 0; i < int'(ReqCnt); i++) begin
          e.kind = ReqWr ? K_WR : K_PAD;
          e.data = ReqWr ? ((i < src.size()) ? src[i].data : 8'hxx) : PAD;
          e.last = (i == int'(ReqCnt) - 1);
          q.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    src_t s;
    @(posedge CLK);
    #1;
    if (src.size() > 0) begin
      s = src[0];
      if (s.gap > 0) begin
        DinValid = 1'b0;
        s.gap--;
        src[0] = s;
      end else begin
        DinValid = 1'b1;
        Din = s.data;
      end
    end else begin
      DinValid = 1'b0;
    end
  endtask

  task automatic clear_logs();
    cap.delete(); wcyc.delete(); dr_seen = 0; stall = 0;
  endtask

  task automatic send(input logic wr, input logic [2:0] a, input logic [2:0] c);
    Req = 1'b1; ReqWr = wr; ReqAddr = a; ReqCnt = c;
    tick();
    Req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (q.size() > 0 && n < 60) begin tick(); n++; end
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL %s: packet not finished after %0d cycles", name, n);
    end
  endtask

  task automatic pin_cap(input string name, input logic [7:0] e[$]);
    chk({name, "_len"}, 8'(cap.size()), 8'(e.size()));
    for (int i = 0; i < e.size(); i++)
      chk(name, (i < cap.size()) ? cap[i] : 8'hxx, e[i]);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] ev[$];
    int n;
    src_t s;
    RSTn = 1'b0; Req = 1'b0; ReqWr = 1'b0; ReqAddr = 3'd0; ReqCnt = 3'd0;
    Din = 8'h00; DinValid = 1'b0; Full = 1'b0;
    repeat (3) tick();
    chk("rst_req_ready", 8'(ReqReady), 8'd1);
    chk("rst_winc", 8'(WINC), 8'd0);
    chk("rst_busy", 8'(Busy), 8'd0);
    chk("rst_din_ready", 8'(DinReady), 8'd0);
    chk("rst_pkt_cnt", PktCnt, 8'h00);
    RSTn = 1'b1;
    tick();

    // Write addr5 cnt3 with continuous data
    s.gap = 0;
    s.data = 8'hA1; src.push_back(s);
    s.data = 8'hA2; src.push_back(s);
    s.data = 8'hA3; src.push_back(s);
    tick(); clear_logs();
    send(1'b1, 3'd5, 3'd3);
    wait_done("t1");
    ev = '{8'hAB, 8'hA1, 8'hA2, 8'hA3};
    pin_cap("t1_bytes", ev);
    chk("t1_consecutive", 8'((wcyc.size() == 4) ? wcyc[3] - wcyc[0] : 99), 8'd3);
    chk("t1_pkt_cnt", PktCnt, 8'd1);
    chk("t1_req_ready", 8'(ReqReady), 8'd1);

    // Same packet with Full held for two header cycles
    s.data = 8'hA1; src.push_back(s);
    s.data = 8'hA2; src.push_back(s);
    s.data = 8'hA3; src.push_back(s);
    tick(); clear_logs();
    send(1'b1, 3'd5, 3'd3);
    Full = 1'b1;
    tick(); tick();
    Full = 1'b0;
    wait_done("t2");
    pin_cap("t2_bytes", ev);
    chk("t2_stall", 8'(stall), 8'd2);
    chk("t2_pkt_cnt", PktCnt, 8'd2);

    // Skip op addr2 cnt2 with an unrelated Din byte pending
    s.data = 8'h55; src.push_back(s);
    tick(); clear_logs();
    send(1'b0, 3'd2, 3'd2);
    wait_done("t3");
    ev = '{8'h12, 8'h00, 8'h00};
    pin_cap("t3_bytes", ev);
    chk("t3_din_ready_seen", 8'(dr_seen), 8'd0);
    chk("t3_din_kept", 8'(src.size()), 8'd1);
    chk("t3_din_valid", 8'(DinValid), 8'd1);
    chk("t3_pkt_cnt", PktCnt, 8'd3);
    src.delete();
    tick();

    // Zero-count write addr7
    clear_logs();
    send(1'b1, 3'd7, 3'd0);
    wait_done("t4");
    ev = '{8'hB8};
    pin_cap("t4_bytes", ev);
    chk("t4_pkt_cnt", PktCnt, 8'd4);
    chk("t4_req_ready", 8'(ReqReady), 8'd1);

    // Two-byte write addr1 with a three-cycle valid gap
    s.data = 8'h11; s.gap = 0; src.push_back(s);
    s.data = 8'h22; s.gap = 3; src.push_back(s);
    tick(); clear_logs();
    send(1'b1, 3'd1, 3'd2);
    wait_done("t5");
    ev = '{8'h8A, 8'h11, 8'h22};
    pin_cap("t5_bytes", ev);
    chk("t5_gap_cycles", 8'(stall), 8'd3);
    chk("t5_pkt_cnt", PktCnt, 8'd5);

    // Reset after the first payload byte of a cnt4 write
    s.gap = 0;
    s.data = 8'hC1; src.push_back(s);
    s.data = 8'hC2; src.push_back(s);
    s.data = 8'hC3; src.push_back(s);
    s.data = 8'hC4; src.push_back(s);
    tick(); clear_logs();
    send(1'b1, 3'd3, 3'd4);
    n = 0;
    while (cap.size() < 2 && n < 40) begin tick(); n++; end
    ev = '{8'h9C, 8'hC1};
    pin_cap("t6_partial", ev);
    RSTn = 1'b0;
    tick();
    RSTn = 1'b1;
    @(negedge CLK);
    #1;
    chk("t6_req_ready", 8'(ReqReady), 8'd1);
    chk("t6_winc", 8'(WINC), 8'd0);
    chk("t6_busy", 8'(Busy), 8'd0);
    chk("t6_pkt_cnt", PktCnt, 8'd0);
    tick();

    // New packet after reset, with Req held while busy
    s.data = 8'hD1; src.push_back(s);
    s.data = 8'hD2; src.push_back(s);
    tick(); clear_logs();
    send(1'b1, 3'd6, 3'd2);
    Req = 1'b1; ReqWr = 1'b0; ReqAddr = 3'd3; ReqCnt = 3'd1;
    tick(); tick();
    Req = 1'b0;
    wait_done("t7");
    tick(); tick();
    ev = '{8'hB2, 8'hD1, 8'hD2};
    pin_cap("t7_bytes", ev);
    chk("t7_pkt_cnt", PktCnt, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
